mem_addr_arbiter: RTL and testbench
===================================

// Module: mem_addr_arbiter
// PURPOSE
//  Drives the shared memory address bus. Arbitrates N_CH requesters onto one registered address/write-enable bus.
//  Channel 0 is instruction fetch (PC, FETCH_W wide, zero-extended); channels 1..N_CH-1 are data (LDR/STR) ports.
//  Each access holds the bus for a programmable number of wait states and ends with a one-cycle ack.
//  Sits between the control unit/register bank and the memory block.
// PARAMETERS
//  ADDR_W       16  memory address width
//  FETCH_W       8  PC width on ch0; zero-extended to ADDR_W; FETCH_W <= ADDR_W
//  N_CH          2  requester count, 2..8; ch0 = fetch
//  WAIT_CYCLES   0  extra cycles mem_en is held beyond the first, 0..15
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  rst        in   1              synchronous reset, active-high
//  req        in   N_CH           per-channel request level
//  req_we     in   N_CH           per-channel write (STR) flag; ch0 input ignored and treated as 0
//  req_addr   in   N_CH*ADDR_W    channel c at [c*ADDR_W +: ADDR_W]; ch0 uses low FETCH_W bits only
//  mem_addr   out  ADDR_W         registered bus address
//  mem_we     out  1              registered write strobe, valid while mem_en=1
//  mem_en     out  1              bus access active
//  grant      out  N_CH           one-hot owner; held through ACCESS and ACK
//  ack        out  N_CH           one-cycle completion pulse to the owner
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; mem_addr=0, mem_we=0, mem_en=0, grant=0, ack=0, busy=0.
//  - rst asserted mid-access: IDLE on the next edge, all outputs 0, no ack for the aborted access.
//  - FSM IDLE -> ACCESS -> ACK -> IDLE; 2-bit encoding.
//    IDLE:   if |req, pick winner w; register mem_addr/mem_we from w, set grant[w], mem_en=1, load cnt=WAIT_CYCLES, go ACCESS.
//    ACCESS: mem_addr, mem_we and grant frozen. Stay while cnt!=0, decrementing cnt each cycle.
//            When cnt==0: mem_en=0, mem_we=0, ack[w]=1, go ACK.
//    ACK:    ack[w] high for exactly this cycle. grant still = w. Clear grant, go IDLE.
//  - Latency: req sampled at edge N -> mem_en high from N+1 for WAIT_CYCLES+1 cycles -> ack high one cycle.
//    Back-to-back accesses have 1 idle cycle between ack and the next mem_en; throughput = 1 access per WAIT_CYCLES+3 cycles.
//  - Requester holds req, req_we and req_addr until ack. A req dropped mid-access does not abort it; ack still pulses.
//  - A channel still requesting in IDLE after its ack is re-arbitrated as a new access.
//  - Addresses are captured at grant only; later input changes are ignored until the next IDLE.
//  - mem_addr holds its last value while idle; it does not follow the inputs.
//  - ch0 address = {ADDR_W-FETCH_W zeros, req_addr[FETCH_W-1:0]}.
//  - Simultaneous requests: the winner is chosen by the selection rule below. Losers wait, with no ack and no grant.
// CONFIGURATION
//  - Macro MEM_ARB_ROUND_ROBIN_EN.
//  - Undefined: fixed priority, highest channel index wins, so data accesses always beat fetch.
//  - Defined: round robin. Pointer p resets to 0. Search starts at (last winner + 1) mod N_CH, ascending with wrap.
//    p updates only on grant. Starvation-free: each requester is served within N_CH grants.
// STRUCTURE
//  - Header mem_ctrl_defs.vh (shared package, `include guarded): FSM state encodings ST_IDLE/ST_ACCESS/ST_ACK.
//    The header also holds default ADDR_W/FETCH_W values shared with memory and register bank.
//  - Sub-module mem_arb_pick (combinational): inputs req and last-winner pointer; outputs one-hot pick and pick index.
//    It contains both selection rules under the macro.
//  - Top holds the FSM, wait counter, address/we capture registers and output registers.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=2'b11 -> all outputs 0, busy=0. Assert rst during ACCESS -> outputs 0 next cycle, no ack.
//  2. Fetch only (WAIT_CYCLES=0): req=01, pc=8'hA5 -> next cycle mem_addr=16'h00A5, mem_en=1, mem_we=0, grant=01;
//     following cycle ack=01, mem_en=0.
//  3. Wait states (WAIT_CYCLES=3): data STR to 16'h1234 -> mem_en high exactly 4 cycles with mem_we=1;
//     ack one cycle later; addr stable throughout.
//  4. Contention, macro off: req=11 held -> ch1 granted every time; ch0 never acked.
//  5. Contention, macro on, N_CH=4, req=1111 held -> grant order 0,1,2,3,0 with one ack per access.
//  6. Mid-access changes: change req_addr and drop req during ACCESS -> mem_addr unchanged, ack still pulses, no new access follows.

Source files
------------

// File: rtl/mem_addr_arbiter_pkg.sv
// Shared definitions for the memory address arbiter: FSM state encodings,
// default bus widths shared with the memory and register bank, and a small
// pointer helper.
package mem_addr_arbiter_pkg;

  // Two-bit FSM encoding for the bus owner sequence.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

  // Default widths shared with the memory block and register bank.
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_FETCH_W = 8;

  // Wait-state counter width; covers WAIT_CYCLES 0..15.
  localparam int CNT_W = 4;

  // Next channel index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory address arbiter.
// Macro MEM_ARB_ROUND_ROBIN_EN: defined -> round robin starting at ptr_i;
// undefined -> fixed priority, highest channel index wins.
module mem_arb_pick #(
  parameter int N_CH  = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_CH-1:0]  req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [N_CH-1:0]  pick_oh_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             valid_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic found;
`endif

  // Select one requester and produce its index and one-hot form.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
    pick_oh_o  = '0;
    pick_idx_o = '0;
    valid_o    = |req_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    found      = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (int'(ptr_i) + k) % N_CH;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        pick_idx_o = IDX_W'(c);
      end
    end
`else
    // Later (higher) indices overwrite earlier ones, so data beats fetch.
    for (int c = 0; c < N_CH; c++) begin
      if (req_i[c]) pick_idx_o = IDX_W'(c);
    end
`endif
    if (valid_o) pick_oh_o[pick_idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_addr_arbiter.sv
// Shared memory address bus arbiter: N_CH requesters (ch0 = instruction
// fetch, others = data ports) onto one registered address/write-enable bus,
// with programmable wait states and a one-cycle ack per access.
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_addr_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FETCH_W     = DEF_FETCH_W,
  parameter int N_CH        = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        req_we,
  input  logic [N_CH*ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_en,
  output logic [N_CH-1:0]        grant,
  output logic [N_CH-1:0]        ack,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_CH);
  // Fetch addresses only carry FETCH_W bits; upper bits are forced to zero.
  localparam logic [ADDR_W-1:0] FETCH_MASK = ~({ADDR_W{1'b1}} << FETCH_W);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               en_q, en_d;
  logic [N_CH-1:0]    grant_q, grant_d;
  logic [N_CH-1:0]    ack_q, ack_d;

  logic [N_CH-1:0]    pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  mem_arb_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .ptr_i      (ptr_q),
`endif
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .valid_o    (pick_valid)
  );

  // Winner's address and write flag; fetch is zero-extended and never writes.
  always_comb begin
    sel_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_we   = req_we[pick_idx];
    if (pick_idx == '0) begin
      sel_addr = sel_addr & FETCH_MASK;
      sel_we   = 1'b0;
    end
  end

  // Next-state and output-register logic for IDLE -> ACCESS -> ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    en_d    = en_q;
    grant_d = grant_q;
    ack_d   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          addr_d  = sel_addr;
          we_d    = sel_we;
          en_d    = 1'b1;
          grant_d = pick_oh;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d   = IDX_W'(wrap_inc(int'(pick_idx), N_CH));
`endif
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          en_d    = 1'b0;
          we_d    = 1'b0;
          ack_d   = grant_q;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign mem_we   = we_q;
  assign mem_en   = en_q;
  assign grant    = grant_q;
  assign ack      = ack_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Self-checking bench for mem_addr_arbiter: one 2-channel zero-wait instance
// and one 4-channel three-wait instance, directed steps plus an ack scoreboard.
module tb_mem_addr_arbiter;

  typedef struct {
    logic [7:0]  ack;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N_CH=2, WAIT_CYCLES=0
  logic [1:0]  req0, we0;
  logic [31:0] addr0;
  logic [15:0] mem_addr0;
  logic        mem_we0, mem_en0, busy0;
  logic [1:0]  grant0, ack0;

  // Instance B: N_CH=4, WAIT_CYCLES=3
  logic [3:0]  req3, we3;
  logic [63:0] addr3;
  logic [15:0] mem_addr3;
  logic        mem_we3, mem_en3, busy3;
  logic [3:0]  grant3, ack3;

  mem_addr_arbiter #(.ADDR_W(16), .FETCH_W(8), .N_CH(2), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .req_we(we0), .req_addr(addr0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_en(mem_en0),
    .grant(grant0), .ack(ack0), .busy(busy0)
  );

  mem_addr_arbiter #(.ADDR_W(16), .FETCH_W(8), .N_CH(4), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req(req3), .req_we(we3), .req_addr(addr3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_en(mem_en3),
    .grant(grant3), .ack(ack3), .busy(busy3)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q3[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [1:0] a, input logic [15:0] ad);
    exp_t e;
    e.ack = {6'd0, a};
    e.addr = ad;
    q0.push_back(e);
  endtask

  task automatic push3(input logic [3:0] a, input logic [15:0] ad);
    exp_t e;
    e.ack = {4'd0, a};
    e.addr = ad;
    q3.push_back(e);
  endtask

  // Scoreboard for instance A: every ack pulse must match the next expected access.
  always @(negedge clk) begin
    if (ack0 != '0) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_ack", {30'd0, ack0}, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("u0_sb_ack", {30'd0, ack0}, {24'd0, e.ack});
        check("u0_sb_addr", {16'd0, mem_addr0}, {16'd0, e.addr});
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (ack3 != '0) begin
      if (q3.size() == 0) begin
        check("u3_unexpected_ack", {28'd0, ack3}, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("u3_sb_ack", {28'd0, ack3}, {24'd0, e.ack});
        check("u3_sb_addr", {16'd0, mem_addr3}, {16'd0, e.addr});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Reset with requests pending
    rst = 1'b1; req0 = 2'b11; we0 = 2'b11; addr0 = 32'h5555_6666;
    req3 = 4'b1111; we3 = 4'b1111; addr3 = '1;
    tick(); tick();
    check("rst_addr", {16'd0, mem_addr0}, 32'h0);
    check("rst_we",   {31'd0, mem_we0}, 32'h0);
    check("rst_en",   {31'd0, mem_en0}, 32'h0);
    check("rst_grant", {30'd0, grant0}, 32'h0);
    check("rst_ack",  {30'd0, ack0}, 32'h0);
    check("rst_busy", {31'd0, busy0}, 32'h0);
    check("rst_busy3", {31'd0, busy3}, 32'h0);
    req0 = '0; we0 = '0; req3 = '0; we3 = '0;
    rst = 1'b0;
    tick();

    // ---- Fetch only, zero waits; upper ch0 bits and ch0 we are ignored
    addr0 = 32'h0000_77A5; req0 = 2'b01; we0 = 2'b01;
    push0(2'b01, 16'h00A5);
    tick();
    check("fetch_addr", {16'd0, mem_addr0}, 32'h00A5);
    check("fetch_en",   {31'd0, mem_en0}, 32'h1);
    check("fetch_we",   {31'd0, mem_we0}, 32'h0);
    check("fetch_grant", {30'd0, grant0}, 32'h1);
    check("fetch_busy", {31'd0, busy0}, 32'h1);
    tick();
    check("fetch_ack",   {30'd0, ack0}, 32'h1);
    check("fetch_en_off", {31'd0, mem_en0}, 32'h0);
    check("fetch_grant_ack", {30'd0, grant0}, 32'h1);
    req0 = '0; we0 = '0;
    tick();
    check("fetch_idle_grant", {30'd0, grant0}, 32'h0);
    check("fetch_idle_ack", {30'd0, ack0}, 32'h0);
    check("fetch_idle_busy", {31'd0, busy0}, 32'h0);
    check("fetch_idle_hold", {16'd0, mem_addr0}, 32'h00A5);

    // ---- Reset during ACCESS: no ack, outputs cleared
    addr0 = 32'hBEEF_0000; req0 = 2'b10; we0 = 2'b10;
    tick();
    check("abort_pre_en", {31'd0, mem_en0}, 32'h1);
    check("abort_pre_we", {31'd0, mem_we0}, 32'h1);
    rst = 1'b1;
    tick();
    check("abort_en",   {31'd0, mem_en0}, 32'h0);
    check("abort_ack",  {30'd0, ack0}, 32'h0);
    check("abort_grant", {30'd0, grant0}, 32'h0);
    check("abort_addr", {16'd0, mem_addr0}, 32'h0);
    check("abort_busy", {31'd0, busy0}, 32'h0);
    rst = 1'b0; req0 = '0; we0 = '0;
    tick(); tick();
    check("abort_no_late_ack", {30'd0, ack0}, 32'h0);

    // ---- Contention on instance A, requests held for three accesses
    addr0 = 32'h4321_3312; req0 = 2'b11; we0 = 2'b11;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push0(2'b01, 16'h0012); push0(2'b10, 16'h4321); push0(2'b01, 16'h0012);
`else
    push0(2'b10, 16'h4321); push0(2'b10, 16'h4321); push0(2'b10, 16'h4321);
`endif
    tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("cont_first_grant", {30'd0, grant0}, 32'h1);
`else
    check("cont_first_grant", {30'd0, grant0}, 32'h2);
    check("cont_first_we", {31'd0, mem_we0}, 32'h1);
`endif
    for (int i = 0; i < 8; i++) tick();
    req0 = '0; we0 = '0;
    tick(); tick();
    check("cont_done_busy", {31'd0, busy0}, 32'h0);
    check("cont_q_empty", q0.size(), 32'd0);

    // ---- Wait states on instance B: STR to 16'h1234, mem_en high four cycles
    addr3 = 64'h0000_0000_1234_0000; req3 = 4'b0010; we3 = 4'b0010;
    push3(4'b0010, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ws_en_%0d", i), {31'd0, mem_en3}, 32'h1);
      check($sformatf("ws_we_%0d", i), {31'd0, mem_we3}, 32'h1);
      check($sformatf("ws_addr_%0d", i), {16'd0, mem_addr3}, 32'h1234);
      check($sformatf("ws_ack_%0d", i), {28'd0, ack3}, 32'h0);
    end
    tick();
    check("ws_en_off", {31'd0, mem_en3}, 32'h0);
    check("ws_we_off", {31'd0, mem_we3}, 32'h0);
    check("ws_ack", {28'd0, ack3}, 32'h2);
    check("ws_grant_ack", {28'd0, grant3}, 32'h2);
    req3 = '0; we3 = '0;
    tick();
    check("ws_idle", {31'd0, busy3}, 32'h0);

    // ---- Mid-access changes: address change and dropped req are ignored
    addr3 = 64'h0000_0AB0_0000_0000; req3 = 4'b0100; we3 = 4'b0000;
    push3(4'b0100, 16'h0AB0);
    tick();
    addr3 = '1; req3 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_addr_%0d", i), {16'd0, mem_addr3}, 32'h0AB0);
    end
    tick();
    check("mid_ack", {28'd0, ack3}, 32'h4);
    tick(); tick();
    check("mid_no_new_en", {31'd0, mem_en3}, 32'h0);
    check("mid_no_busy", {31'd0, busy3}, 32'h0);
    check("mid_addr_hold", {16'd0, mem_addr3}, 32'h0AB0);

    // ---- Four-way contention on instance B from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr3 = 64'h1003_1002_1001_1000; req3 = 4'b1111; we3 = 4'b0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push3(4'b0001, 16'h0000); push3(4'b0010, 16'h1001);
    push3(4'b0100, 16'h1002); push3(4'b1000, 16'h1003);
    push3(4'b0001, 16'h0000);
`else
    for (int i = 0; i < 5; i++) push3(4'b1000, 16'h1003);
`endif
    tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("rr_first_grant", {28'd0, grant3}, 32'h1);
`else
    check("rr_first_grant", {28'd0, grant3}, 32'h8);
`endif
    for (int i = 0; i < 29; i++) tick();
    req3 = '0;
    tick(); tick();
    check("rr_done_busy", {31'd0, busy3}, 32'h0);
    check("rr_q_empty", q3.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
